// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller. Owns the PC, drives the
// instruction-memory address and buffers fetched words in a 2-entry FIFO
// toward decode. Handles redirects (with flush), ebreak halt and fetch faults.
//
// state | meaning
// IDLE  | waiting for start_i, no fetch
// RUN   | fetching, accepting redirects
// HALT  | stopped (ebreak or fault); queue still drains, reset required to leave
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic [15:0] pc_o,
  input  logic [31:0] instr_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [31:0] dec_instr_o,
  output logic [15:0] dec_pc_o,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic        halt_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [16:0] IM_LIMIT = 17'(IM_WORDS);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  // slot 0 is always the head; slot 1 is the younger entry
  logic [15:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;

  logic        pop;
  logic        enq;
  logic        flush;
  logic        out_of_range;
  logic [1:0]  cnt_after_pop;

  assign pop          = (count_q != 2'd0) && dec_ready_i;
  assign out_of_range = ({3'b000, pc_q[15:2]} >= IM_LIMIT);

  // Next-state, PC and queue update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    pc0_d         = pc0_q;
    instr0_d      = instr0_q;
    pc1_d         = pc1_q;
    instr1_d      = instr1_q;
    enq           = 1'b0;
    flush         = 1'b0;
    cnt_after_pop = count_q;

    if (pop) begin
      pc0_d         = pc1_q;
      instr0_d      = instr1_q;
      cnt_after_pop = count_q - 2'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_i) begin
          // redirect beats any fetch-side event this cycle
          flush = 1'b1;
          pc_d  = redirect_pc_i;
          if (redirect_pc_i[1:0] != 2'b00) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end
        end else if ((count_q != 2'd2) || pop) begin
          if (out_of_range) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            enq  = 1'b1;
            pc_d = pc_q + 16'd4;
            if (instr_i == EBREAK) state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // fetch only happens with room after the pop, so cnt_after_pop <= 1 here
    if (enq) begin
      if (cnt_after_pop == 2'd0) begin
        pc0_d    = pc_q;
        instr0_d = instr_i;
      end else begin
        pc1_d    = pc_q;
        instr1_d = instr_i;
      end
    end

    if (flush)    count_d = 2'd0;
    else if (enq) count_d = cnt_after_pop + 2'd1;
    else          count_d = cnt_after_pop;
  end

  // State, PC, fault and queue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      fault_q  <= 1'b0;
      pc0_q    <= 16'h0000;
      pc1_q    <= 16'h0000;
      instr0_q <= 32'h0000_0000;
      instr1_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
    end
  end

  assign pc_o        = pc_q;
  assign dec_valid_o = (count_q != 2'd0);
  assign dec_pc_o    = pc0_q;
  assign dec_instr_o = instr0_q;
  assign halt_o      = (state_q == ST_HALT);
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model of the fetch controller.
module tb_fetch_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JUNK   = 32'h0BAD_0013;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] pc_o;
  logic [31:0] instr_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [15:0] dec_pc_o;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        halt_o;
  logic        fault_o;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc;
  int          m_st;
  logic        m_fault;

  fetch_ctrl #(.RESET_PC(16'h0000), .IM_WORDS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pc_o         (pc_o),
    .instr_i      (instr_i),
    .dec_valid_o  (dec_valid_o),
    .dec_ready_i  (dec_ready_i),
    .dec_instr_o  (dec_instr_o),
    .dec_pc_o     (dec_pc_o),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .halt_o       (halt_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    if (a[15:8] == 8'h00) return mem[a[7:2]];
    return JUNK;
  endfunction

  assign instr_i = word_at(pc_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input int ebreak_idx);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == EBREAK) w = w ^ 32'h1;
      mem[i] = w;
    end
    mem[0] = 32'h0560_0513;
    mem[1] = 32'h0055_12f3;
    mem[2] = 32'h0050_22f3;
    mem[3] = 32'h005b_5573;
    if (ebreak_idx >= 0) mem[ebreak_idx] = EBREAK;
  endtask

  task automatic model_reset();
    q.delete();
    m_pc    = 16'h0000;
    m_st    = M_IDLE;
    m_fault = 1'b0;
  endtask

  // one clock of the reference behaviour, written from the queue's point of view
  task automatic model_step(input logic s, input logic r, input logic rd, input logic [15:0] rpc);
    bit   pop;
    bit   room;
    ent_t e;
    pop  = (q.size() > 0) && r;
    room = (q.size() < 2) || pop;
    if (m_st == M_RUN) begin
      if (rd) begin
        q.delete();
        m_pc = rpc;
        if (rpc % 4 != 0) begin
          m_st    = M_HALT;
          m_fault = 1'b1;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (room) begin
          if ((int'(m_pc) / 4) >= 64) begin
            m_st    = M_HALT;
            m_fault = 1'b1;
          end else begin
            e.pc  = m_pc;
            e.ins = word_at(m_pc);
            q.push_back(e);
            m_pc = m_pc + 16'd4;
            if (e.ins == EBREAK) m_st = M_HALT;
          end
        end
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (m_st == M_IDLE && s) m_st = M_RUN;
    end
  endtask

  task automatic check_outputs();
    check("pc_o", {16'h0, pc_o}, {16'h0, m_pc});
    check("dec_valid", {31'h0, dec_valid_o}, {31'h0, q.size() > 0});
    if (q.size() > 0) begin
      check("dec_pc", {16'h0, dec_pc_o}, {16'h0, q[0].pc});
      check("dec_instr", dec_instr_o, q[0].ins);
    end
    check("halt", {31'h0, halt_o}, {31'h0, m_st == M_HALT});
    check("fault", {31'h0, fault_o}, {31'h0, m_fault});
  endtask

  // called at posedge+1; drives one cycle of inputs and checks after the edge
  task automatic step(input logic s, input logic r, input logic rd, input logic [15:0] rpc);
    start_i       = s;
    dec_ready_i   = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    model_step(s, r, rd, rpc);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    start_i       = 1'b0;
    dec_ready_i   = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 16'h0000;
    rst           = 1'b1;
    model_reset();
    #2;
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load_mem(-1);
    do_reset();

    // start and stream with ready held high
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("start_no_valid", {31'h0, dec_valid_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("first_valid_pc", {16'h0, dec_pc_o}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // backpressure, then release, then redirect with a pop in the same cycle
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    check("bp_pc_hold", {16'h0, pc_o}, 32'h8);
    check("bp_head", {16'h0, dec_pc_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("pre_redir_head", {16'h0, dec_pc_o}, 32'h8);
    step(1'b0, 1'b1, 1'b1, 16'h0014);
    check("redir_bubble", {31'h0, dec_valid_o}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("redir_target", {16'h0, dec_pc_o}, 32'h14);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);

    // ebreak at word 2
    load_mem(2);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    check("ebreak_halt", {31'h0, halt_o}, 32'h1);
    check("ebreak_fault", {31'h0, fault_o}, 32'h0);
    check("ebreak_pc", {16'h0, pc_o}, 32'hC);

    // sequential fetch running off the end of memory
    load_mem(-1);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    check("range_halt", {31'h0, halt_o}, 32'h1);
    check("range_fault", {31'h0, fault_o}, 32'h1);
    check("range_pc", {16'h0, pc_o}, 32'h100);

    // misaligned redirect
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h0102);
    check("misal_halt", {31'h0, halt_o}, 32'h1);
    check("misal_fault", {31'h0, fault_o}, 32'h1);
    check("misal_pc", {16'h0, pc_o}, 32'h102);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0040);

    // asynchronous reset between edges with a full queue
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    check("full_before_rst", {31'h0, dec_valid_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, dec_valid_o}, 32'h0);
    check("arst_pc", {16'h0, pc_o}, 32'h0);
    check("arst_halt", {31'h0, halt_o}, 32'h0);
    check("arst_fault", {31'h0, fault_o}, 32'h0);

    // randomized traffic
    for (int round = 0; round < 8; round++) begin
      load_mem(($urandom % 3 == 0) ? int'($urandom_range(4, 63)) : -1);
      do_reset();
      for (int c = 0; c < 200; c++) begin
        logic        s, r, rd;
        logic [15:0] rpc;
        int          kind;
        s    = ($urandom % 3 == 0);
        r    = ($urandom % 4 != 0);
        rd   = ($urandom % 12 == 0);
        kind = $urandom % 10;
        if (kind < 7)       rpc = {8'h00, 6'($urandom_range(0, 63)), 2'b00};
        else if (kind == 7) rpc = {8'h00, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        else if (kind == 8) rpc = 16'h00FC;
        else                rpc = 16'h0100;
        step(s, r, rd, rpc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
